// File: rtl/ball_motion_if.sv
// Ball motion bus: vsync/keycode into the mover, ball position and frame tick out.
// master drives the inputs (video/keyboard side); slave is the ball_motion block.
interface ball_motion_if;
  logic       vsync;
  logic [7:0] keycode;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] Ball_size;
  logic       frame_tick;

  modport master (output vsync, keycode, input BallX, BallY, Ball_size, frame_tick);
  modport slave  (input vsync, keycode, output BallX, BallY, Ball_size, frame_tick);
endinterface

// File: rtl/ball_motion.sv
// Keyboard-steered ball that moves one STEP per vsync falling edge and bounces off edges.
// Optional macro BALL_RECENTER_EN: keycode 0x15 (R) recentres the ball and stops it.
module ball_motion #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE     = 4,
  parameter int STEP     = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  ball_motion_if.slave  bus
);

  typedef enum logic [2:0] {STOP, UP, DOWN, LEFT, RIGHT} dir_t;

  localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
  localparam logic [10:0] SIZE_W   = 11'(SIZE);
  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [9:0]  X_CTR_10 = 10'(X_CENTER);
  localparam logic [9:0]  Y_CTR_10 = 10'(Y_CENTER);
  localparam logic [9:0]  SIZE_10  = 10'(SIZE);

  dir_t       state_q, state_d, dir_key;
  logic [9:0] ball_x_q, ball_y_q, ball_x_d, ball_y_d;
  logic [10:0] x11, y11;
  logic       vsync_p0, vsync_p1, vsync_p2, tick_q;

  // Compare in 11 bits, then drop to the 10-bit coordinate range.
  function automatic logic [9:0] step_up(input logic [10:0] v);
    logic [10:0] s;
    s = v + STEP_W;
    return s[9:0];
  endfunction

  function automatic logic [9:0] step_down(input logic [10:0] v);
    logic [10:0] s;
    s = v - STEP_W;
    return s[9:0];
  endfunction

  // Stage p0/p1: synchroniser, p2: delay flop; tick is the registered falling edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vsync_p0 <= 1'b1;
      vsync_p1 <= 1'b1;
      vsync_p2 <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      vsync_p0 <= bus.vsync;
      vsync_p1 <= vsync_p0;
      vsync_p2 <= vsync_p1;
      tick_q   <= vsync_p2 & ~vsync_p1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= STOP;
      ball_x_q <= X_CTR_10;
      ball_y_q <= Y_CTR_10;
    end else if (tick_q) begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
    end
  end

  always_comb begin
    x11     = {1'b0, ball_x_q};
    y11     = {1'b0, ball_y_q};
    dir_key = state_q;
    case (bus.keycode)
      8'h1A:   dir_key = UP;
      8'h16:   dir_key = DOWN;
      8'h04:   dir_key = LEFT;
      8'h07:   dir_key = RIGHT;
      8'h2C:   dir_key = STOP;
      default: dir_key = state_q;
    endcase

    state_d  = dir_key;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    // A wall already touched wins over the key pressed toward it.
    case (dir_key)
      RIGHT: if (x11 + SIZE_W >= X_MAX_W) begin
               state_d  = LEFT;
               ball_x_d = step_down(x11);
             end else ball_x_d = step_up(x11);
      LEFT:  if (x11 <= X_MIN_W + SIZE_W) begin
               state_d  = RIGHT;
               ball_x_d = step_up(x11);
             end else ball_x_d = step_down(x11);
      DOWN:  if (y11 + SIZE_W >= Y_MAX_W) begin
               state_d  = UP;
               ball_y_d = step_down(y11);
             end else ball_y_d = step_up(y11);
      UP:    if (y11 <= Y_MIN_W + SIZE_W) begin
               state_d  = DOWN;
               ball_y_d = step_up(y11);
             end else ball_y_d = step_down(y11);
      default: ;
    endcase

`ifdef BALL_RECENTER_EN
    if (bus.keycode == 8'h15) begin
      state_d  = STOP;
      ball_x_d = X_CTR_10;
      ball_y_d = Y_CTR_10;
    end
`else
`endif
  end

  always_comb begin
    bus.BallX      = ball_x_q;
    bus.BallY      = ball_y_q;
    bus.Ball_size  = SIZE_10;
    bus.frame_tick = tick_q;
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: table of per-frame keycodes plus edge/reset sequences.
module tb_ball_motion;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;
  int   wide_cnt = 0;
  logic prev_tick = 1'b0;
  int   lat;

  ball_motion_if bus();

  ball_motion dut (.Clk(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_tick) tick_cnt++;
    if (bus.frame_tick && prev_tick) wide_cnt++;
    prev_tick = bus.frame_tick;
  end

  typedef struct {
    logic [7:0] key;
    int         x;
    int         y;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One vsync low pulse; lat records how many Clk after the fall frame_tick appeared.
  task automatic frame();
    lat = 0;
    bus.vsync = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.frame_tick && lat == 0) lat = i;
    end
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    bus.vsync = 1'b1;
    bus.keycode = 8'h00;

    vecs[0]  = '{8'h00, 320, 240};
    vecs[1]  = '{8'h07, 321, 240};
    vecs[2]  = '{8'h07, 322, 240};
    vecs[3]  = '{8'h00, 323, 240};
    vecs[4]  = '{8'h1A, 323, 239};
    vecs[5]  = '{8'h99, 323, 238};
    vecs[6]  = '{8'h2C, 323, 238};
    vecs[7]  = '{8'h00, 323, 238};
    vecs[8]  = '{8'h04, 322, 238};
    vecs[9]  = '{8'h16, 322, 239};
`ifdef BALL_RECENTER_EN
    vecs[10] = '{8'h15, 320, 240};
    vecs[11] = '{8'h00, 320, 240};
    vecs[12] = '{8'h07, 321, 240};
`else
    vecs[10] = '{8'h15, 322, 240};
    vecs[11] = '{8'h00, 322, 241};
    vecs[12] = '{8'h2C, 322, 241};
`endif

    repeat (3) @(negedge clk);
    chk("reset_x", int'(bus.BallX), 320);
    chk("reset_y", int'(bus.BallY), 240);
    chk("reset_size", int'(bus.Ball_size), 4);
    chk("reset_tick", int'(bus.frame_tick), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_tick_after_release", tick_cnt, 0);

    // Five idle frames: no movement, five single-cycle ticks, 3-Clk latency.
    for (int f = 0; f < 5; f++) begin
      frame();
      if (f == 0) chk("tick_latency", lat, 3);
    end
    chk("idle_x", int'(bus.BallX), 320);
    chk("idle_y", int'(bus.BallY), 240);
    chk("idle_tick_count", tick_cnt, 5);
    chk("tick_width", wide_cnt, 0);

    // Table: one frame per row.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus.keycode = vecs[i].key;
      frame();
      chk($sformatf("vec%0d_x", i), int'(bus.BallX), vecs[i].x);
      chk($sformatf("vec%0d_y", i), int'(bus.BallY), vecs[i].y);
    end

    // Right wall bounce.
    do_reset();
    bus.keycode = 8'h07;
    repeat (315) frame();
    chk("right_635", int'(bus.BallX), 635);
    frame();
    chk("right_bounce_634", int'(bus.BallX), 634);
    bus.keycode = 8'h00;
    frame();
    chk("right_after_633", int'(bus.BallX), 633);

    // Left wall bounce with A held.
    bus.keycode = 8'h04;
    repeat (627) frame();
    chk("left_6", int'(bus.BallX), 6);
    frame();
    chk("left_5", int'(bus.BallX), 5);
    frame();
    chk("left_4", int'(bus.BallX), 4);
    frame();
    chk("left_bounce_5", int'(bus.BallX), 5);
    chk("left_y_hold", int'(bus.BallY), 240);

    // Top wall bounce then stop.
    do_reset();
    bus.keycode = 8'h1A;
    repeat (236) frame();
    chk("up_4", int'(bus.BallY), 4);
    frame();
    chk("up_bounce_5", int'(bus.BallY), 5);
    chk("up_x_hold", int'(bus.BallX), 320);
    bus.keycode = 8'h2C;
    for (int k = 0; k < 3; k++) begin
      frame();
      chk($sformatf("stop_hold%0d", k), int'(bus.BallY), 5);
    end

    // Asynchronous reset between vsync edges.
    do_reset();
    bus.keycode = 8'h07;
    repeat (80) frame();
    chk("mid_400", int'(bus.BallX), 400);
    t0 = tick_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_x", int'(bus.BallX), 320);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_tick_after_mid_reset", tick_cnt, t0);
    frame();
    chk("tick_after_mid_reset", tick_cnt, t0 + 1);
    chk("move_after_mid_reset", int'(bus.BallX), 321);

    // Recentre key at (600,100) moving UP.
    do_reset();
    bus.keycode = 8'h07;
    repeat (280) frame();
    bus.keycode = 8'h1A;
    repeat (140) frame();
    chk("pre_r_x", int'(bus.BallX), 600);
    chk("pre_r_y", int'(bus.BallY), 100);
    bus.keycode = 8'h15;
    frame();
`ifdef BALL_RECENTER_EN
    chk("r_x", int'(bus.BallX), 320);
    chk("r_y", int'(bus.BallY), 240);
    bus.keycode = 8'h00;
    frame();
    chk("r_stop_y", int'(bus.BallY), 240);
`else
    chk("r_x", int'(bus.BallX), 600);
    chk("r_y", int'(bus.BallY), 99);
    bus.keycode = 8'h00;
    frame();
    chk("r_cont_y", int'(bus.BallY), 98);
`endif
    chk("final_tick_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
